// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: start/data/stop bit timing, RX byte FIFO and CPB/CFG/STATUS/RDR registers.
// Optional parity check is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CPB_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        rx_sync,
  input  logic [7:0]  rx_byte,
  output logic        bit_tick,
  output logic        rx_clr,
  output logic        irq
);
  // Bus: bus_we/bus_re are single-cycle strobes that are always accepted (no stall);
  // bus_rdata is registered and valid in the cycle after bus_re, 0 otherwise.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_HALF, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HALF, S_DATA, S_STOP} state_t;
`endif

  state_t           state;
  logic [CPB_W-1:0] cpb, cpb_l, cnt;
  logic [2:0]       bitn;
  logic             cfg_en, cfg_irq_en;
  logic             push_pend, ovr, ferr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [5:0]       count6;
  logic [31:0]      status_word, rd_mux;
  logic             sel_cpb, sel_cfg, sel_sts, sel_rdr;
  logic             enabled, not_empty, full, busy, pop, flush, w1c;
  logic             stop_fire, ferr_set, ovr_set, do_push, frame_ok, flags_any;
  logic             unused_bits;

  assign sel_cpb   = (bus_addr == 4'h0);
  assign sel_cfg   = (bus_addr == 4'h4);
  assign sel_sts   = (bus_addr == 4'h8);
  assign sel_rdr   = (bus_addr == 4'hC);
  assign enabled   = cfg_en && (cpb >= CPB_W'(4));
  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign busy      = (state != S_IDLE);
  assign pop       = bus_re && sel_rdr && not_empty;
  assign flush     = bus_we && sel_cfg && bus_wdata[2];
  assign w1c       = bus_we && sel_sts;
  assign stop_fire = enabled && (state == S_STOP) && (cnt == '0);
  assign ferr_set  = stop_fire && !rx_sync;
  // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
  assign do_push   = push_pend && (!full || pop) && !flush;
  assign ovr_set   = push_pend && full && !pop && !flush;
  assign count6    = 6'(count);
  assign unused_bits = ^{bus_wdata, count6[5]};

`ifdef UART_RX_PARITY_EN
  logic cfg_par_en, cfg_odd, perr, perr_set, par_bad;
  assign perr_set  = enabled && (state == S_PARITY) && (cnt == '0) &&
                     (rx_sync != ((^rx_byte) ^ cfg_odd));
  assign frame_ok  = !par_bad;
  assign flags_any = not_empty | ovr | ferr | perr;
`else
  assign frame_ok  = 1'b1;
  assign flags_any = not_empty | ovr | ferr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cpb_l     <= '0;
      cnt       <= '0;
      bitn      <= '0;
      bit_tick  <= 1'b0;
      rx_clr    <= 1'b0;
      push_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      bit_tick  <= 1'b0;
      rx_clr    <= 1'b0;
      push_pend <= stop_fire && rx_sync && frame_ok;
      if (!enabled) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (!rx_sync) begin
            state  <= S_HALF;
            cpb_l  <= cpb;
            cnt    <= (cpb >> 1) - 1'b1;
            rx_clr <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
          S_HALF: begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else if (rx_sync) state <= S_IDLE;
            else begin
              state <= S_DATA;
              cnt   <= cpb_l - 1'b1;
              bitn  <= '0;
            end
          end
          S_DATA: begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
              bit_tick <= 1'b1;
              bitn     <= bitn + 1'b1;
              cnt      <= cpb_l - 1'b1;
`ifdef UART_RX_PARITY_EN
              if (bitn == 3'd7) state <= cfg_par_en ? S_PARITY : S_STOP;
`else
              if (bitn == 3'd7) state <= S_STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
              par_bad <= perr_set;
              state   <= S_STOP;
              cnt     <= cpb_l - 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= rx_byte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(pop);
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = not_empty;
    status_word[1]    = full;
    status_word[2]    = ovr;
    status_word[3]    = ferr;
    status_word[4]    = busy;
    status_word[12:8] = count6[4:0];
`ifdef UART_RX_PARITY_EN
    status_word[5]    = perr;
`endif
    rd_mux = '0;
    if (sel_cpb) rd_mux[CPB_W-1:0] = cpb;
    if (sel_cfg) begin
      rd_mux[0] = cfg_en;
      rd_mux[1] = cfg_irq_en;
`ifdef UART_RX_PARITY_EN
      rd_mux[3] = cfg_par_en;
      rd_mux[4] = cfg_odd;
`endif
    end
    if (sel_sts) rd_mux = status_word;
    if (sel_rdr && not_empty) rd_mux[7:0] = mem[rd_ptr];
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpb        <= '0;
      cfg_en     <= 1'b0;
      cfg_irq_en <= 1'b0;
      ovr        <= 1'b0;
      ferr       <= 1'b0;
      irq        <= 1'b0;
      bus_rdata  <= '0;
`ifdef UART_RX_PARITY_EN
      cfg_par_en <= 1'b0;
      cfg_odd    <= 1'b0;
      perr       <= 1'b0;
`endif
    end else begin
      if (bus_we && sel_cpb) cpb <= bus_wdata[CPB_W-1:0];
      if (bus_we && sel_cfg) begin
        cfg_en     <= bus_wdata[0];
        cfg_irq_en <= bus_wdata[1];
`ifdef UART_RX_PARITY_EN
        cfg_par_en <= bus_wdata[3];
        cfg_odd    <= bus_wdata[4];
`endif
      end
      ovr  <= ovr_set  | (ovr  & ~(w1c & bus_wdata[2]));
      ferr <= ferr_set | (ferr & ~(w1c & bus_wdata[3]));
`ifdef UART_RX_PARITY_EN
      perr <= perr_set | (perr & ~(w1c & bus_wdata[5]));
`endif
      irq       <= cfg_irq_en & flags_any;
      bus_rdata <= bus_re ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl; a behavioural shift register plays the receiver.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam logic [3:0] A_CPB = 4'h0, A_CFG = 4'h4, A_STS = 4'h8, A_RDR = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  bus_addr;
  logic        bus_we, bus_re;
  logic [31:0] bus_wdata, bus_rdata;
  logic        rx_sync;
  logic [7:0]  rx_byte;
  logic        bit_tick, rx_clr, irq;

  int          n_checks = 0, n_fail = 0;
  int          tick_total = 0, clr_total = 0;
  logic [7:0]  exp_q[$];
  int          tick_log[$];
  logic [31:0] inj_rdata;

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  uart_rx_ctrl #(.FIFO_DEPTH(8), .CPB_W(16)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .rx_sync(rx_sync), .rx_byte(rx_byte),
    .bit_tick(bit_tick), .rx_clr(rx_clr), .irq(irq)
  );

  // clock / reset-side models
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || rx_clr) rx_byte <= 8'h00;
    else if (bit_tick) rx_byte <= {rx_sync, rx_byte[7:1]};
    if (!rst && bit_tick) tick_total <= tick_total + 1;
    if (!rst && rx_clr)   clr_total  <= clr_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk); bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk); bus_addr = a; bus_re = 1'b1;
    @(negedge clk); bus_re = 1'b0; d = bus_rdata;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic rdr_check(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    bus_read(A_RDR, d);
    check(name, d, {24'h0, e});
  endtask

  // Drives one frame LSB first; optionally injects one bus access at negedge index inj_at.
  // tick_log records, relative to the start-detect edge, each edge that raised bit_tick.
  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit,
                            input logic par_en, input logic par_bit, input int inj_at,
                            input logic inj_we, input logic [3:0] inj_addr,
                            input logic [31:0] inj_wdata);
    int nbits;
    int len;
    logic [10:0] slots;
    nbits = par_en ? 11 : 10;
    len   = nbits * cpb + 8;
    slots = par_en ? {stop_bit, par_bit, b, 1'b0} : {1'b1, stop_bit, b, 1'b0};
    tick_log.delete();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (bit_tick) tick_log.push_back(i - 1);
      if (inj_at >= 0 && i == inj_at + 1) begin
        bus_we = 1'b0; bus_re = 1'b0; inj_rdata = bus_rdata;
      end
      if (i == inj_at) begin
        bus_addr = inj_addr; bus_wdata = inj_wdata; bus_we = inj_we; bus_re = !inj_we;
      end
      rx_sync = (i / cpb < nbits) ? slots[i / cpb] : 1'b1;
    end
  endtask

  task automatic send_ok(input logic [7:0] b, input int cpb);
    exp_q.push_back(b);
    send_frame(b, cpb, 1'b1, 1'b0, 1'b0, -1, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    int clr0, tick0, first, last;
    rst = 1'b1; bus_addr = 4'h0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = '0; rx_sync = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_bit_tick", {31'h0, bit_tick}, 32'h0);
    check("reset_rx_clr",   {31'h0, rx_clr},   32'h0);
    check("reset_irq",      {31'h0, irq},      32'h0);
    check("reset_rdata",    bus_rdata,         32'h0);
    rst = 1'b0;

    // register-map vectors
    vecs.push_back('{"rst_cpb",   1'b0, A_CPB, 32'h0,         32'h0});
    vecs.push_back('{"rst_cfg",   1'b0, A_CFG, 32'h0,         32'h0});
    vecs.push_back('{"rst_sts",   1'b0, A_STS, 32'h0,         32'h0});
    vecs.push_back('{"rdr_empty", 1'b0, A_RDR, 32'h0,         32'h0});
    vecs.push_back('{"unmapped",  1'b0, 4'h1,  32'h0,         32'h0});
    vecs.push_back('{"w_cpb",     1'b1, A_CPB, 32'hFFFF_1234, 32'h0});
    vecs.push_back('{"cpb_trunc", 1'b0, A_CPB, 32'h0,         32'h0000_1234});
    vecs.push_back('{"w_cfg",     1'b1, A_CFG, 32'hFFFF_FFFF, 32'h0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{"cfg_bits",  1'b0, A_CFG, 32'h0,         32'h0000_001B});
`else
    vecs.push_back('{"cfg_bits",  1'b0, A_CFG, 32'h0,         32'h0000_0003});
`endif
    vecs.push_back('{"w_unmap",   1'b1, 4'h2,  32'h0000_0055, 32'h0});
    vecs.push_back('{"cpb_kept",  1'b0, A_CPB, 32'h0,         32'h0000_1234});
    vecs.push_back('{"w_sts",     1'b1, A_STS, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{"sts_ro",    1'b0, A_STS, 32'h0,         32'h0});
    vecs.push_back('{"w_cfg0",    1'b1, A_CFG, 32'h0,         32'h0});
    vecs.push_back('{"cfg_zero",  1'b0, A_CFG, 32'h0,         32'h0});
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].we) bus_write(vecs[v].addr, vecs[v].wdata);
      else read_check(vecs[v].name, vecs[v].addr, vecs[v].exp);
    end

    // CPB below 4 keeps the receiver idle
    bus_write(A_CPB, 32'd3);
    bus_write(A_CFG, 32'h1);
    clr0 = clr_total;
    @(negedge clk); rx_sync = 1'b0;
    repeat (10) @(negedge clk);
    read_check("cpb3_idle", A_STS, 32'h0);
    check("cpb3_no_clr", clr_total - clr0, 32'h0);
    rx_sync = 1'b1;

    // 0xA5 at CPB=16: ticks at 24 + 16k, busy mid-frame
    bus_write(A_CPB, 32'd16);
    clr0 = clr_total;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b0, 50, 1'b0, A_STS, 32'h0);
    check("a5_ticks", tick_log.size(), 32'd8);
    for (int k = 0; k < 8; k++)
      check("a5_tick_pos", (k < tick_log.size()) ? tick_log[k] : -1, 24 + 16 * k);
    check("a5_busy", inj_rdata, 32'h10);
    check("a5_clr", clr_total - clr0, 32'h1);
    read_check("a5_sts", A_STS, 32'h101);
    rdr_check("a5_rdr");
    read_check("a5_sts_empty", A_STS, 32'h0);

    // 3-cycle low glitch: false start
    clr0 = clr_total; tick0 = tick_total;
    @(negedge clk); rx_sync = 1'b0;
    repeat (3) @(negedge clk);
    rx_sync = 1'b1;
    read_check("glitch_busy", A_STS, 32'h10);
    repeat (12) @(negedge clk);
    read_check("glitch_idle", A_STS, 32'h0);
    check("glitch_clr", clr_total - clr0, 32'h1);
    check("glitch_ticks", tick_total - tick0, 32'h0);

    // overflow: nine bytes into eight entries
    bus_write(A_CPB, 32'd4);
    bus_write(A_CFG, 32'h3);
    for (int k = 0; k < 8; k++) send_ok(8'h11 * 8'(k + 1), 4);
    send_frame(8'hEE, 4, 1'b1, 1'b0, 1'b0, -1, 1'b0, 4'h0, 32'h0);
    read_check("ovr_sts", A_STS, 32'h807);
    check("ovr_irq", {31'h0, irq}, 32'h1);
    bus_write(A_STS, 32'h4);
    read_check("ovr_w1c", A_STS, 32'h803);

    // pop and push on the same edge while full
    send_frame(8'h5A, 4, 1'b1, 1'b0, 1'b0, 39, 1'b0, A_RDR, 32'h0);
    check("full_pop", inj_rdata, {24'h0, (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00});
    exp_q.push_back(8'h5A);
    read_check("full_popush_sts", A_STS, 32'h803);
    for (int k = 0; k < 8; k++) rdr_check("fifo_order");
    read_check("drained", A_STS, 32'h0);
    check("irq_clear", {31'h0, irq}, 32'h0);

    // framing error, with a W1C of FERR on the stop-sample edge
    send_frame(8'h33, 4, 1'b0, 1'b0, 1'b0, 38, 1'b1, A_STS, 32'h8);
    read_check("ferr_set_wins", A_STS, 32'h8);
    check("ferr_irq", {31'h0, irq}, 32'h1);
    bus_write(A_STS, 32'h8);
    read_check("ferr_w1c", A_STS, 32'h0);

    // flush on the push edge
    send_frame(8'h44, 4, 1'b1, 1'b0, 1'b0, 39, 1'b1, A_CFG, 32'h7);
    read_check("flush_wins", A_STS, 32'h0);

    // disable during data bit 3, then flush a non-empty FIFO
    bus_write(A_CFG, 32'h1);
    send_ok(8'h81, 4);
    send_frame(8'hC3, 4, 1'b1, 1'b0, 1'b0, 16, 1'b1, A_CFG, 32'h0);
    check("dis_ticks", tick_log.size(), 32'd3);
    read_check("dis_sts", A_STS, 32'h101);
    bus_write(A_CFG, 32'h4);
    exp_q.delete();
    read_check("dis_flushed", A_STS, 32'h0);
    read_check("dis_rdr_empty", A_RDR, 32'h0);

`ifdef UART_RX_PARITY_EN
    // odd parity: 0x01 needs parity bit 0
    bus_write(A_CFG, 32'h19);
    send_frame(8'h01, 4, 1'b1, 1'b1, 1'b1, -1, 1'b0, 4'h0, 32'h0);
    read_check("perr_set", A_STS, 32'h20);
    bus_write(A_STS, 32'h20);
    read_check("perr_w1c", A_STS, 32'h0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 4, 1'b1, 1'b1, 1'b0, -1, 1'b0, 4'h0, 32'h0);
    read_check("par_ok_sts", A_STS, 32'h101);
    rdr_check("par_ok_rdr");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
